// File: rtl/floating_point_normalize_round.sv
// Post-add normalize/round stage: turns a raw mantissa sum plus exponent into a packed
// IEEE-754 single using a 1-bit/cycle left normalizer and round-to-nearest-even.
module floating_point_normalize_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sign_in,
  input  logic [EXP_W-1:0]      exp_in,
  input  logic [FRAC_W+4:0]     mant_in,
  output logic                  done,
  output logic [EXP_W+FRAC_W:0] result,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  inexact,
  output logic [2:0]            state_dbg
);

  // Handshake: done=1 means idle with result/flags valid and held. A start seen at a clock
  // edge while done=1 is accepted and its operands are captured in that same cycle; start
  // while done=0 is ignored. done returns to 1 at the edge that publishes the new result.

  localparam int MW  = FRAC_W + 5;
  localparam int XW  = EXP_W + 2;
  localparam int CRY = MW - 1;
  localparam int HID = MW - 2;
  localparam int RW  = MW - 3;

  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
  localparam logic signed [XW-1:0] EXP_TWO = XW'(2);
  localparam logic signed [XW-1:0] EXP_INF = XW'((1 << EXP_W) - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_NORM   = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_RENORM = 3'd4;
  localparam logic [2:0] S_PACK   = 3'd5;

  logic [2:0]               state_q, state_d;
  logic                     sign_q, sign_d;
  logic signed [XW-1:0]     exp_q, exp_d;
  logic [MW-1:0]            mant_q, mant_d;
  logic                     zero_q, zero_d;
  logic                     grs_q, grs_d;
  logic [EXP_W+FRAC_W:0]    result_q, result_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  logic                     inx_q, inx_d;

  logic                     rnd_up;
  logic [RW-1:0]            rnd_sum;

  // Nearest-even: round up above half, or at exactly half when the kept LSB is odd.
  assign rnd_up  = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
  assign rnd_sum = {1'b0, mant_q[HID:3]} + RW'(rnd_up);

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    zero_d   = zero_q;
    grs_d    = grs_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d  = sign_in;
          exp_d   = {2'b00, exp_in};
          mant_d  = mant_in;
          zero_d  = 1'b0;
          grs_d   = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inx_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mant_q == '0) begin
          zero_d  = 1'b1;
          state_d = S_PACK;
        end else if (mant_q[CRY]) begin
          // Both bits leaving the bottom fold into sticky so rounding stays exact.
          mant_d  = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
          exp_d   = exp_q + EXP_ONE;
          state_d = S_ROUND;
        end else if (mant_q[HID]) begin
          state_d = S_ROUND;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (exp_q == EXP_ONE) begin
          state_d = S_ROUND;
        end else begin
          mant_d = {mant_q[MW-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
          if (mant_q[HID-1] || exp_q == EXP_TWO) state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        mant_d  = {rnd_sum, 3'b000};
        grs_d   = |mant_q[2:0];
        state_d = rnd_sum[RW-1] ? S_RENORM : S_PACK;
      end
      S_RENORM: begin
        mant_d  = {1'b0, mant_q[MW-1:1]};
        exp_d   = exp_q + EXP_ONE;
        state_d = S_PACK;
      end
      S_PACK: begin
        if (exp_q >= EXP_INF) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_d    = 1'b1;
          inx_d    = 1'b1;
        end else if (zero_q) begin
          result_d = {sign_q, {(EXP_W + FRAC_W){1'b0}}};
        end else if (!mant_q[HID]) begin
          result_d = {sign_q, {EXP_W{1'b0}}, mant_q[HID-1:3]};
          unf_d    = 1'b1;
          inx_d    = grs_q;
        end else begin
          result_d = {sign_q, exp_q[EXP_W-1:0], mant_q[HID-1:3]};
          inx_d    = grs_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      zero_q   <= 1'b0;
      grs_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      zero_q   <= zero_d;
      grs_q    <= grs_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  assign done      = (state_q == S_IDLE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_floating_point_normalize_round.sv
// Bench for floating_point_normalize_round: directed corner vectors, randomized operands
// against an exact-arithmetic round-to-nearest-even model, busy-start and reset-abort cases.
module tb_floating_point_normalize_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [27:0] mant_in;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;
  logic [2:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard entries are {overflow, underflow, inexact, result}.
  logic [34:0] exp_q[$];
  int          lat_q[$];

  floating_point_normalize_round dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Exact reference: locate the MSB, pick the final exponent (clamped at 1 for denormals),
  // then round the exact integer value at the resulting LSB position to nearest-even.
  function automatic void ref_model(input logic s, input int e, input logic [27:0] m,
                                    output logic [31:0] r, output logic [2:0] fl,
                                    output int lat);
    int          p, ef, lsb, nl;
    logic [63:0] q, rem, half, mm;
    bit          up, ren;
    fl  = 3'b000;
    ren = 1'b0;
    if (m == 28'h0) begin
      r   = {s, 31'h0};
      lat = 3;
      return;
    end
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    ef = e + p - 26;
    if (ef < 1) ef = 1;
    lsb = 3 + ef - e;
    mm  = 64'(m);
    if (lsb > 0) begin
      q    = mm >> lsb;
      rem  = mm & ((64'd1 << lsb) - 64'd1);
      half = 64'd1 << (lsb - 1);
      up   = (rem > half) || (rem == half && q[0]);
    end else begin
      q   = mm << (-lsb);
      rem = 64'd0;
      up  = 1'b0;
    end
    fl[0] = (rem != 64'd0);
    q = q + 64'(up);
    if (q >= (64'd1 << 24)) begin
      q   = q >> 1;
      ef  = ef + 1;
      ren = 1'b1;
    end
    if (ef >= 255) begin
      r  = {s, 8'hFF, 23'h0};
      fl = 3'b101;
    end else if (q < (64'd1 << 23)) begin
      r     = {s, 8'h00, q[22:0]};
      fl[1] = 1'b1;
    end else begin
      r = {s, 8'(ef), q[22:0]};
    end
    if (p >= 26)               nl = 0;
    else if (e == 1)           nl = 1;
    else if (26 - p < e - 1)   nl = 26 - p;
    else                       nl = e - 1;
    lat = 4 + nl + int'(ren);
  endfunction

  // Driver: called at posedge+#1 with done=1. Latency counts edges from the start edge
  // (inclusive) to the edge where done rises (inclusive).
  task automatic drive_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                          output logic [31:0] r, output logic [2:0] fl,
                          output int lat, output bit tmo);
    tmo     = 1'b0;
    sign_in = s;
    exp_in  = e;
    mant_in = m;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    sign_in = 1'($urandom);
    exp_in  = 8'($urandom);
    mant_in = 28'($urandom);
    lat     = 1;
    n_vec++;
    while (!done && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) tmo = 1'b1;
    r  = result;
    fl = {overflow, underflow, inexact};
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    start   = 1'b0;
    sign_in = 1'b0;
    exp_in  = 8'h0;
    mant_in = 28'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL reset_done got=%b want=1", done);
    end
    if (result !== 32'h0) begin
      n_err++; $display("FAIL reset_result got=%h want=00000000", result);
    end
    if ({overflow, underflow, inexact} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got=%b want=000", {overflow, underflow, inexact});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic        ds[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0]  de[9]  = '{8'd127, 8'd130, 8'd127, 8'd127, 8'd254, 8'd100, 8'd3, 8'd1, 8'd127};
    logic [27:0] dm[9]  = '{28'h8000000, 28'h0800000, 28'h7FFFFFC, 28'h4000004, 28'h8000000,
                            28'h0000000, 28'h0000008, 28'h3FFFFFC, 28'h4000006};
    logic [31:0] dr[9]  = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h7F800000,
                            32'h80000000, 32'h00000004, 32'h00800000, 32'h3F800001};
    logic [2:0]  dfl[9] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b101, 3'b000, 3'b010, 3'b001, 3'b001};
    int          dl[9]  = '{4, 7, 5, 4, 4, 3, 6, 5, 4};
    logic [31:0] r;
    logic [2:0]  fl;
    int          lat;
    bit          tmo;
    for (int i = 0; i < 9; i++) begin
      drive_op(ds[i], de[i], dm[i], r, fl, lat, tmo);
      if (tmo) begin
        n_err++; $display("FAIL directed_timeout vec=%0d got=busy want=done", i);
      end
      if (r !== dr[i]) begin
        n_err++; $display("FAIL directed_result vec=%0d got=%h want=%h", i, r, dr[i]);
      end
      if (fl !== dfl[i]) begin
        n_err++; $display("FAIL directed_flags vec=%0d got=%b want=%b", i, fl, dfl[i]);
      end
      if (lat != dl[i]) begin
        n_err++; $display("FAIL directed_latency vec=%0d got=%0d want=%0d", i, lat, dl[i]);
      end
    end
  endtask

  task automatic test_random();
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [31:0] er, r;
    logic [2:0]  efl, fl;
    logic [34:0] want;
    int          elat, lat, want_lat;
    bit          tmo;
    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom);
      e = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(30, 1)) : 8'($urandom_range(254, 1));
      m = 28'($urandom) >> $urandom_range(27, 0);
      if ($urandom_range(19, 0) == 0) m = 28'h0;
      if ($urandom_range(9, 0) == 0) m = m | 28'h8000000;
      ref_model(s, int'(e), m, er, efl, elat);
      exp_q.push_back({efl, er});
      lat_q.push_back(elat);
      drive_op(s, e, m, r, fl, lat, tmo);
      want     = exp_q.pop_front();
      want_lat = lat_q.pop_front();
      if (tmo) begin
        n_err++; $display("FAIL random_timeout op=%0d got=busy want=done", i);
      end
      if ({fl, r} !== want) begin
        n_err++;
        $display("FAIL random_result op=%0d in=%b/%0d/%h got=%b/%h want=%b/%h",
                 i, s, e, m, fl, r, want[34:32], want[31:0]);
      end
      if (lat != want_lat) begin
        n_err++; $display("FAIL random_latency op=%0d in=%0d/%h got=%0d want=%0d", i, e, m, lat, want_lat);
      end
    end
  endtask

  task automatic test_busy_start();
    logic [31:0] er, hold_r;
    logic [2:0]  efl;
    int          elat, cyc;
    ref_model(1'b1, 100, 28'h0000100, er, efl, elat);
    sign_in = 1'b1;
    exp_in  = 8'd100;
    mant_in = 28'h0000100;
    start   = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    // Competing request held for three busy cycles must be dropped, not queued.
    sign_in = 1'b0;
    exp_in  = 8'd254;
    mant_in = 28'h8000000;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    cyc   = 4;
    while (!done && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) begin
      n_err++; $display("FAIL busy_timeout got=busy want=done");
    end
    if ({overflow, underflow, inexact, result} !== {efl, er}) begin
      n_err++;
      $display("FAIL busy_result got=%b/%h want=%b/%h", {overflow, underflow, inexact}, result, efl, er);
    end
    if (cyc != elat) begin
      n_err++; $display("FAIL busy_latency got=%0d want=%0d", cyc, elat);
    end
    hold_r = er;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    if (done !== 1'b1 || result !== hold_r) begin
      n_err++; $display("FAIL busy_hold got=%b/%h want=1/%h", done, result, hold_r);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    logic [2:0]  fl;
    int          lat;
    bit          tmo;
    drive_op(1'b0, 8'd254, 28'h8000000, r, fl, lat, tmo);
    if (fl !== 3'b101) begin
      n_err++; $display("FAIL abort_preflags got=%b want=101", fl);
    end
    sign_in = 1'b1;
    exp_in  = 8'd127;
    mant_in = 28'h0000001;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_vec++;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    if (done !== 1'b1 || result !== 32'h0) begin
      n_err++; $display("FAIL abort_state got=%b/%h want=1/00000000", done, result);
    end
    if ({overflow, underflow, inexact} !== 3'b000) begin
      n_err++; $display("FAIL abort_flags got=%b want=000", {overflow, underflow, inexact});
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    if (done !== 1'b1 || result !== 32'h0) begin
      n_err++; $display("FAIL abort_no_publish got=%b/%h want=1/00000000", done, result);
    end
    drive_op(1'b0, 8'd127, 28'h4000004, r, fl, lat, tmo);
    if (r !== 32'h3F800000 || fl !== 3'b001 || lat != 4 || tmo) begin
      n_err++; $display("FAIL abort_next1 got=%h/%b/%0d want=3f800000/001/4", r, fl, lat);
    end
    drive_op(1'b0, 8'd127, 28'h8000000, r, fl, lat, tmo);
    if (r !== 32'h40000000 || fl !== 3'b000 || lat != 4 || tmo) begin
      n_err++; $display("FAIL abort_next2 got=%h/%b/%0d want=40000000/000/4", r, fl, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_start();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
